// File: rtl/bitty_core_gen2.sv
// bitty_core_gen2: four-state multi-cycle core, eight WIDTH-bit registers.
// Macro BITTY_IMM_EN enables the fmt 01 zero-extended imm8 operand.
module bitty_core_gen2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [15:0]      instruction,
    output logic             done,
    output logic             illegal,
    output logic             flag_c,
    output logic             flag_z,
    input  logic [2:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXEC,
        WRITE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] regs [8];
    logic [15:0]      ir;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;

    logic [2:0]       rx;
    logic [2:0]       ry;
    logic [2:0]       op;
    logic [1:0]       fmt;
    logic             bad;
    logic             is_cmp;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   sum;
    logic             alu_c;
    logic             alu_z;

    assign rx     = ir[15:13];
    assign ry     = ir[12:10];
    assign op     = ir[4:2];
    assign fmt    = ir[1:0];
    assign is_cmp = (op == 3'b111);

`ifdef BITTY_IMM_EN
    logic [7:0] imm8;
    assign imm8 = ir[12:5];
    assign bad  = fmt[1];
    assign opnd = fmt[0] ? WIDTH'(imm8) : regs[ry];
`else
    assign bad  = (fmt != 2'b00);
    assign opnd = regs[ry];
`endif

    assign dbg_data = regs[dbg_sel];

    // ALU: S against the decoded operand, unsigned, truncated to WIDTH
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sum     = '0;
        unique case (op)
            3'b000: begin
                sum     = {1'b0, s} + {1'b0, opnd};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            3'b001: begin
                alu_res = s - opnd;
                alu_c   = (s < opnd);
            end
            3'b010: alu_res = s & opnd;
            3'b011: alu_res = s | opnd;
            3'b100: alu_res = s ^ opnd;
            3'b101: alu_res = s << opnd[SW-1:0];
            3'b110: alu_res = s >> opnd[SW-1:0];
            default: begin
                alu_res = s - opnd;
                alu_c   = (s < opnd);
            end
        endcase
        alu_z = is_cmp ? (s == opnd) : (alu_res == '0);
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: one edge per state, run only matters in IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (run) state_nxt = LOAD;
            LOAD:    state_nxt = EXEC;
            EXEC:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: IR capture, S load, ALU result/flags, writeback and done
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            ir      <= '0;
            s       <= '0;
            c       <= '0;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (run) ir <= instruction;
                end
                LOAD: s <= regs[rx];
                EXEC: begin
                    if (!bad) begin
                        c      <= alu_res;
                        flag_c <= alu_c;
                        flag_z <= alu_z;
                    end
                end
                WRITE: begin
                    if (!bad && !is_cmp) regs[rx] <= c;
                    done    <= 1'b1;
                    illegal <= bad;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/bitty_core_gen2.md
BITTY_CORE_GEN2 -- requirements
Module: bitty_core_gen2

Interface
REQ-001 SHALL have parameter: WIDTH, 16, datapath/register width in bits; legal range 8..64.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: run  input  1  request to issue the instruction on `instruction`.
REQ-005 SHALL have port: instruction  input  16  instruction word, sampled only when accepted.
REQ-006 SHALL have port: done  output  1  one-cycle pulse on instruction retirement.
REQ-007 SHALL have port: illegal  output  1  one-cycle pulse, coincident with done, for an illegal instruction.
REQ-008 SHALL have port: flag_c  output  1  registered carry/borrow flag.
REQ-009 SHALL have port: flag_z  output  1  registered zero/equal flag.
REQ-010 SHALL have port: dbg_sel  input  3  debug register-file read select.
REQ-011 SHALL have port: dbg_data  output  WIDTH  combinational read of R[dbg_sel].

Function
REQ-012 SHALL decode: rx=[15:13]; fmt=[1:0]; op=[4:2]; fmt 00 operand = R[[12:10]]; fmt 01 operand = imm8 [12:5] zero-extended to WIDTH; fmt 1x illegal.
REQ-013 SHALL hold eight WIDTH-bit registers R0..R7, plus internal IR (16b), S and C (WIDTH each).
REQ-014 SHALL implement FSM IDLE->LOAD->EXEC->WRITE->IDLE, one edge per state, no stalls.
REQ-015 SHALL, in IDLE with run=1, latch instruction into IR and go to LOAD; in IDLE with run=0, stay in IDLE.
REQ-016 SHALL ignore run in LOAD, EXEC and WRITE; no queuing.
REQ-017 SHALL, in LOAD, set S <= R[rx].
REQ-018 SHALL, in EXEC, set C <= ALU(S, operand) and update flags.
REQ-019 SHALL, in WRITE, set R[rx] <= C unless op is cmp or the instruction is illegal.
REQ-020 SHALL assert done for exactly the cycle after the WRITE edge, with R[rx] already updated: run sampled at edge N gives done high in cycle N+4; run held high issues one instruction per 4 cycles.
REQ-021 SHALL implement ops (unsigned, result truncated to WIDTH):
- 000 add: flag_c = carry out of bit WIDTH-1.
- 001 sub a-b: flag_c = borrow (a<b).
- 010 and, 011 or, 100 xor: flag_c = 0.
- 101 shl and 110 shr (logical): shift amount = operand[$clog2(WIDTH)-1:0]; flag_c = 0.
- 111 cmp: flag_c = (a<b), flag_z = (a==b); no writeback.
REQ-022 SHALL set flag_z = (result==0) for every non-cmp legal op.
REQ-023 SHALL, for an illegal instruction, leave registers and flags unchanged, keep the 4-cycle latency, and pulse done and illegal together.
REQ-024 SHALL, when rx equals the ry register index, read R[rx] for both operands.

Reset
REQ-025 SHALL, while reset=1 at an edge, clear R0..R7, IR, S, C, flag_c, flag_z, done and illegal to 0 and force IDLE; reset takes priority over run.
REQ-026 SHALL, on reset mid-instruction, abort with no writeback, no done pulse, and accept run from the first edge after reset deasserts.

Configuration
REQ-027 SHALL support macro BITTY_IMM_EN.
- Defined: fmt 01 is the immediate format per REQ-012.
- Undefined: fmt 01 is illegal per REQ-023, and the immediate mux is not synthesised.

Verification
REQ-028 SHALL cover reset state: reset 2 cycles -> dbg_data=0 for dbg_sel 0..7; done=illegal=flag_c=flag_z=0.
REQ-029 SHALL cover immediate issue: run 1 cycle with 0x20A1 (R1 = R1 + 5) -> done exactly 4 cycles later; dbg_sel=1 reads 0x0005; flag_z=0.
REQ-030 SHALL cover wrap: R2 = R2 - imm 1 -> R2=0xFFFF, flag_c=1. Then R2 = R2 + imm 1 -> R2=0x0000, flag_c=1, flag_z=1.
REQ-031 SHALL cover cmp: R1=5, R3=7, cmp rx=1 ry=3 -> flag_c=1, flag_z=0, R1 still 0x0005, done pulses.
REQ-032 SHALL cover reset abort: assert reset during EXEC of R4 += imm 9 -> no done, R4=0; next instruction retires normally 4 cycles after issue.
REQ-033 SHALL cover back-to-back and illegal: run held high across three instructions -> done every 4th cycle, mid-instruction values ignored; fmt=11 -> illegal=done=1, state unchanged; without BITTY_IMM_EN, 0x20A1 -> illegal=1, R1 unchanged.
